program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8: program memory address width.
REQ-002 Parameter OPC_W, default 4: opcode width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in, input, OPC_W: opcode presented on switches.
REQ-006 Port enter, input, 1: synchronised key level; rising edge requests a write of `in`.
REQ-007 Port finish, input, 1: synchronised key level; rising edge ends loading.
REQ-008 Port wr_en, output, 1: program memory write strobe, one cycle per write.
REQ-009 Port wr_addr, output, ADDR_W: program memory write address.
REQ-010 Port wr_data, output, OPC_W: program memory write data.
REQ-011 Port go, output, 1: one-cycle pulse that starts the execution FSM.
REQ-012 Port loading, output, 1: high while the block accepts opcodes.
REQ-013 Port full, output, 1: high when no opcode slot remains.
REQ-014 Port bad_op, output, 1: one-cycle pulse when an entered opcode is rejected.
REQ-015 Port count, output, ADDR_W: number of opcodes written, excluding the stop opcode.
REQ-016 Port checksum, output, 8: modulo-256 sum of the written opcodes.

Function
REQ-017 Valid opcodes SHALL be 0000-0111 (< > + - [ ] . ,); 1111 (stop) is never written via enter; 1000-1110 and 1111 on enter SHALL pulse bad_op and write nothing.
REQ-018 States SHALL be LOAD, WRITE, TERM, GO, DONE.
REQ-019 First opcode SHALL be written at address 1. The executor increments PC before its first read, so address 0 is never written.
REQ-020 LOAD: enter rising edge with valid `in` and !full -> WRITE; enter rising edge while full -> ignored, no bad_op.
REQ-021 WRITE (1 cycle): wr_en=1, wr_addr=count+1, wr_data=captured `in`; count increments on exit; -> LOAD.
REQ-022 LOAD: finish rising edge -> TERM. finish takes priority over a simultaneous enter edge, and that enter edge is dropped.
REQ-023 TERM (1 cycle): wr_en=1, wr_addr=count+1, wr_data=1111; -> GO.
REQ-024 GO (1 cycle): go=1; -> DONE.
REQ-025 DONE: outputs held, all key edges ignored; the only exit is reset.
REQ-026 full SHALL be (count == 2^ADDR_W-2), which reserves the last address for stop.
REQ-027 Edge detection SHALL use a registered previous level. A key held high yields exactly one request.
REQ-028 `in` SHALL be captured on the cycle the edge is detected and held through WRITE.
REQ-029 loading=1 only in LOAD and WRITE.
REQ-030 wr_en SHALL never be high outside WRITE and TERM.

Reset
REQ-031 Reset SHALL force: state LOAD; count=0; wr_en=0; wr_addr=0; wr_data=0; go=0; bad_op=0; checksum=0; edge registers=0.
REQ-032 Reset asserted mid-WRITE or mid-TERM SHALL take priority; that cycle's write is suppressed.
REQ-033 A key held high across reset release SHALL NOT generate an edge.

Configuration
REQ-034 With PROG_CHECKSUM_EN defined, checksum SHALL add each written opcode (zero-extended, stop excluded) on WRITE, wrapping mod 256.
REQ-035 Without PROG_CHECKSUM_EN, checksum SHALL be constant 0 and no adder is built.

Structure
REQ-036 Shared package bf_pkg SHALL hold the opcode constants (SMALLER..COMMA, STOP_C=1111), OPC_W, and an is_valid_op function. The execution FSM and this block both use it.
REQ-037 One sub-module, bf_edge_detect (level in, one-cycle rise pulse out), SHALL be instantiated for enter and for finish.

Verification
REQ-038 Reset; enter `+`(0010), `.`(0110), finish -> writes (1,0010), (2,0110), (3,1111); go pulses once; count=2.
REQ-039 Enter held high 20 cycles with in=0000 -> exactly one write at address 1; count=1.
REQ-040 Enter in=1010 -> bad_op one-cycle pulse; no wr_en; count unchanged.
REQ-041 ADDR_W=3: 6 valid entries -> full=1; 7th enter ignored; finish writes 1111 at address 7.
REQ-042 enter and finish rise in the same cycle -> only stop written at count+1; go pulses.
REQ-043 Reset during TERM -> no write; state LOAD; count=0. With PROG_CHECKSUM_EN, after entries 0111, 0111 the checksum is 14.

Source files
------------

// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg -- shared definitions for the program loader and the execution FSM.
//
// Holds the opcode width, the eight language opcodes plus the stop opcode,
// the loader state encoding and a helper that classifies an opcode as one
// the user may enter.
// -----------------------------------------------------------------------------
package bf_pkg;

   localparam int OPC_W = 4;

   // Language opcodes, as seen in program memory.
   localparam logic [OPC_W-1:0] SMALLER = 4'b0000;  // <
   localparam logic [OPC_W-1:0] GREATER = 4'b0001;  // >
   localparam logic [OPC_W-1:0] PLUS    = 4'b0010;  // +
   localparam logic [OPC_W-1:0] MINUS   = 4'b0011;  // -
   localparam logic [OPC_W-1:0] OPEN_B  = 4'b0100;  // [
   localparam logic [OPC_W-1:0] CLOSE_B = 4'b0101;  // ]
   localparam logic [OPC_W-1:0] DOT     = 4'b0110;  // .
   localparam logic [OPC_W-1:0] COMMA   = 4'b0111;  // ,
   // Terminates the program; only the loader itself writes it.
   localparam logic [OPC_W-1:0] STOP_C  = 4'b1111;

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_WRITE = 3'd1,
      S_TERM  = 3'd2,
      S_GO    = 3'd3,
      S_DONE  = 3'd4
   } ld_state_e;

   // An opcode may be entered by the user only if it is one of the eight
   // language opcodes; the stop code and the unused codes are rejected.
   function automatic logic is_valid_op(input logic [OPC_W-1:0] op);
      return (op <= COMMA);
   endfunction

endpackage

// File: rtl/bf_edge_detect.sv
// -----------------------------------------------------------------------------
// bf_edge_detect -- one-cycle rising-edge pulse from a synchronised key level.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   level  in  synchronised key level
//   rise   out one-cycle pulse on a 0->1 transition of level
//
// The previous level is registered. An extra "armed" flop, cleared by reset,
// blocks the pulse for the first cycle after reset so that a key already held
// down across reset release is not mistaken for a fresh press.
// -----------------------------------------------------------------------------
module bf_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic prev_q, prev_d;
   logic armed_q, armed_d;

   always_comb begin
      prev_d  = level;
      armed_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         armed_q <= armed_d;
      end
   end

   assign rise = level & ~prev_q & armed_q;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader -- loads opcodes from switches into program memory, then
// terminates the program with the stop opcode and kicks the executor.
//
// Parameters:
//   ADDR_W  program memory address width
//   OPC_W   opcode width
//
// Ports:
//   clk       in   clock, all state on rising edge
//   reset     in   synchronous active-high reset
//   in        in   opcode on switches
//   enter     in   key level; rising edge writes `in`
//   finish    in   key level; rising edge ends loading
//   wr_en     out  program memory write strobe
//   wr_addr   out  program memory write address
//   wr_data   out  program memory write data
//   go        out  one-cycle start pulse for the executor
//   loading   out  high while opcodes are accepted
//   full      out  no opcode slot left (last address kept for stop)
//   bad_op    out  one-cycle pulse when an entered opcode is rejected
//   count     out  opcodes written, stop excluded
//   checksum  out  mod-256 sum of written opcodes
//
// Build option: define PROG_CHECKSUM_EN to build the checksum accumulator;
// otherwise checksum is tied to zero.
//
// Address 0 is never written: the executor pre-increments its PC, so the
// first opcode lands at address 1 and every write goes to count+1.
// -----------------------------------------------------------------------------
module program_loader
   import bf_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int OPC_W  = bf_pkg::OPC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OPC_W-1:0]  in,
   input  logic              enter,
   input  logic              finish,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [OPC_W-1:0]  wr_data,
   output logic              go,
   output logic              loading,
   output logic              full,
   output logic              bad_op,
   output logic [ADDR_W-1:0] count,
   output logic [7:0]        checksum
);

   ld_state_e         state_q, state_d;
   logic [OPC_W-1:0]  in_q, in_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] next_addr;
   logic              enter_rise, finish_rise;
   logic              op_ok;

   bf_edge_detect u_enter_ed (
      .clk   (clk),
      .reset (reset),
      .level (enter),
      .rise  (enter_rise)
   );

   bf_edge_detect u_finish_ed (
      .clk   (clk),
      .reset (reset),
      .level (finish),
      .rise  (finish_rise)
   );

   assign op_ok     = is_valid_op(in);
   assign next_addr = count_q + ADDR_W'(1);
   // Top address is reserved for the stop opcode.
   assign full      = (count_q == ({ADDR_W{1'b1}} - ADDR_W'(1)));
   assign count     = count_q;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOAD;
         in_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         count_q <= count_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      in_d    = in_q;
      count_d = count_q;
      unique case (state_q)
         S_LOAD: begin
            // finish wins; a simultaneous enter edge is dropped.
            if (finish_rise) begin
               state_d = S_TERM;
            end else if (enter_rise && !full && op_ok) begin
               state_d = S_WRITE;
               in_d    = in;
            end
         end
         S_WRITE: begin
            count_d = next_addr;
            state_d = S_LOAD;
         end
         S_TERM:  state_d = S_GO;
         S_GO:    state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_LOAD;
      endcase
   end

   // ---------------- outputs ----------------
   // Strobes are gated by reset so a reset landing in WRITE or TERM
   // suppresses that cycle's memory write.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      go      = 1'b0;
      bad_op  = 1'b0;
      loading = (state_q == S_LOAD) || (state_q == S_WRITE);
      if (!reset) begin
         unique case (state_q)
            S_LOAD: begin
               // Full silently ignores enter, so no reject pulse then.
               bad_op = !finish_rise && enter_rise && !full && !op_ok;
            end
            S_WRITE: begin
               wr_en   = 1'b1;
               wr_addr = next_addr;
               wr_data = in_q;
            end
            S_TERM: begin
               wr_en   = 1'b1;
               wr_addr = next_addr;
               wr_data = OPC_W'(STOP_C);
            end
            S_GO:    go = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef PROG_CHECKSUM_EN
   logic [7:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (state_q == S_WRITE)
         checksum_d = checksum_q + 8'(in_q);
   end

   always_ff @(posedge clk) begin
      if (reset) checksum_q <= '0;
      else       checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
   import bf_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in = '0;
   logic       enter = 1'b0;
   logic       finish = 1'b0;

   logic       wr_en, go, loading, full, bad_op;
   logic [7:0] wr_addr, count, checksum;
   logic [3:0] wr_data;

   logic       wr_en3, go3, loading3, full3, bad_op3;
   logic [2:0] wr_addr3, count3;
   logic [3:0] wr_data3;
   logic [7:0] checksum3;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   program_loader #(.ADDR_W(8), .OPC_W(4)) dut (
      .clk(clk), .reset(reset), .in(in), .enter(enter), .finish(finish),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .go(go),
      .loading(loading), .full(full), .bad_op(bad_op), .count(count),
      .checksum(checksum)
   );

   program_loader #(.ADDR_W(3), .OPC_W(4)) dut3 (
      .clk(clk), .reset(reset), .in(in), .enter(enter), .finish(finish),
      .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .go(go3),
      .loading(loading3), .full(full3), .bad_op(bad_op3), .count(count3),
      .checksum(checksum3)
   );

   // write / pulse logs, sampled on the falling edge
   int         nwr = 0, ngo = 0, nbad = 0;
   logic [7:0] wa [0:15];
   logic [3:0] wd [0:15];
   int         nwr3 = 0, ngo3 = 0, nbad3 = 0;
   logic [2:0] wa3 [0:15];
   logic [3:0] wd3 [0:15];

   always @(negedge clk) begin
      if (wr_en) begin
         if (nwr < 16) begin wa[nwr] = wr_addr; wd[nwr] = wr_data; end
         nwr++;
      end
      if (go) ngo++;
      if (bad_op) nbad++;
      if (wr_en3) begin
         if (nwr3 < 16) begin wa3[nwr3] = wr_addr3; wd3[nwr3] = wr_data3; end
         nwr3++;
      end
      if (go3) ngo3++;
      if (bad_op3) nbad3++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      nwr = 0; ngo = 0; nbad = 0;
      nwr3 = 0; ngo3 = 0; nbad3 = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; enter = 1'b0; finish = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      clear_logs();
   endtask

   task automatic press(input logic [3:0] op);
      in = op; enter = 1'b1;
      tick();
      enter = 1'b0;
      tick(); tick();
   endtask

   task automatic push_finish();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      tick(); tick(); tick();
   endtask

   initial begin
      // ---- reset state ----
      reset = 1'b1;
      tick(); tick();
      chk("rst_wr_en",   32'(wr_en),    32'd0);
      chk("rst_wr_addr", 32'(wr_addr),  32'd0);
      chk("rst_wr_data", 32'(wr_data),  32'd0);
      chk("rst_go",      32'(go),       32'd0);
      chk("rst_bad_op",  32'(bad_op),   32'd0);
      chk("rst_count",   32'(count),    32'd0);
      chk("rst_cksum",   32'(checksum), 32'd0);
      chk("rst_loading", 32'(loading),  32'd1);
      chk("rst_full",    32'(full),     32'd0);
      reset = 1'b0;
      tick(); tick();
      clear_logs();

      // ---- + . finish ----
      press(PLUS);
      press(DOT);
      chk("seq_count2", 32'(count), 32'd2);
      finish = 1'b1;
      tick();                         // now in TERM
      finish = 1'b0;
      chk("term_wr_en",   32'(wr_en),   32'd1);
      chk("term_wr_addr", 32'(wr_addr), 32'd3);
      chk("term_wr_data", 32'(wr_data), 32'hF);
      chk("term_loading", 32'(loading), 32'd0);
      tick();                         // GO
      chk("go_pulse", 32'(go), 32'd1);
      tick();                         // DONE
      chk("done_go",    32'(go),    32'd0);
      chk("done_wr_en", 32'(wr_en), 32'd0);
      chk("seq_nwr",   32'(nwr), 32'd3);
      chk("seq_a0",    32'(wa[0]), 32'd1);
      chk("seq_d0",    32'(wd[0]), 32'h2);
      chk("seq_a1",    32'(wa[1]), 32'd2);
      chk("seq_d1",    32'(wd[1]), 32'h6);
      chk("seq_a2",    32'(wa[2]), 32'd3);
      chk("seq_d2",    32'(wd[2]), 32'hF);
      chk("seq_ngo",   32'(ngo), 32'd1);
      chk("seq_count", 32'(count), 32'd2);
`ifdef PROG_CHECKSUM_EN
      chk("seq_cksum", 32'(checksum), 32'd8);
`else
      chk("seq_cksum", 32'(checksum), 32'd0);
`endif
      // keys ignored in DONE
      press(PLUS);
      push_finish();
      chk("done_ign_nwr", 32'(nwr), 32'd3);
      chk("done_ign_ngo", 32'(ngo), 32'd1);

      // ---- enter held 20 cycles ----
      do_reset();
      in = SMALLER; enter = 1'b1;
      repeat (20) tick();
      enter = 1'b0;
      tick(); tick();
      chk("hold_nwr",   32'(nwr),   32'd1);
      chk("hold_a0",    32'(wa[0]), 32'd1);
      chk("hold_d0",    32'(wd[0]), 32'h0);
      chk("hold_count", 32'(count), 32'd1);

      // ---- rejected opcodes ----
      in = 4'hA; enter = 1'b1;
      #1;
      chk("bad_pulse", 32'(bad_op), 32'd1);
      tick();
      chk("bad_one_cycle", 32'(bad_op), 32'd0);
      enter = 1'b0;
      tick(); tick();
      chk("bad_nwr",   32'(nwr),   32'd1);
      chk("bad_count", 32'(count), 32'd1);
      chk("bad_nbad",  32'(nbad),  32'd1);
      press(STOP_C);
      chk("stop_nbad", 32'(nbad),  32'd2);
      chk("stop_nwr",  32'(nwr),   32'd1);

      // ---- fill ADDR_W=3 instance ----
      do_reset();
      press(PLUS); press(MINUS); press(OPEN_B); press(CLOSE_B); press(GREATER);
      chk("fill5_full3", 32'(full3), 32'd0);
      press(COMMA);
      chk("fill6_full3",  32'(full3),  32'd1);
      chk("fill6_count3", 32'(count3), 32'd6);
      chk("fill6_full8",  32'(full),   32'd0);
      press(DOT);
      chk("full_ign_nwr3",  32'(nwr3),  32'd6);
      chk("full_ign_nbad3", 32'(nbad3), 32'd0);
      chk("full_ign_cnt3",  32'(count3), 32'd6);
      push_finish();
      chk("full_nwr3", 32'(nwr3),   32'd7);
      chk("full_a6",   32'(wa3[6]), 32'd7);
      chk("full_d6",   32'(wd3[6]), 32'hF);
      chk("full_ngo3", 32'(ngo3),   32'd1);

      // ---- enter and finish together ----
      do_reset();
      in = PLUS; enter = 1'b1; finish = 1'b1;
      tick();
      enter = 1'b0; finish = 1'b0;
      tick(); tick(); tick();
      chk("both_nwr",   32'(nwr),   32'd1);
      chk("both_a0",    32'(wa[0]), 32'd1);
      chk("both_d0",    32'(wd[0]), 32'hF);
      chk("both_ngo",   32'(ngo),   32'd1);
      chk("both_count", 32'(count), 32'd0);

      // ---- reset during TERM ----
      do_reset();
      press(COMMA);
      press(COMMA);
`ifdef PROG_CHECKSUM_EN
      chk("ck_14", 32'(checksum), 32'd14);
`else
      chk("ck_14", 32'(checksum), 32'd0);
`endif
      finish = 1'b1;
      tick();                         // TERM
      finish = 1'b0;
      reset = 1'b1;
      #1;
      chk("rterm_wr_en", 32'(wr_en), 32'd0);
      tick();
      reset = 1'b0;
      tick(); tick(); tick();
      chk("rterm_nwr",     32'(nwr),      32'd2);
      chk("rterm_ngo",     32'(ngo),      32'd0);
      chk("rterm_count",   32'(count),    32'd0);
      chk("rterm_loading", 32'(loading),  32'd1);
      chk("rterm_cksum",   32'(checksum), 32'd0);

      // ---- key held across reset release ----
      enter = 1'b1; in = PLUS;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      clear_logs();
      repeat (4) tick();
      enter = 1'b0;
      tick();
      chk("held_rel_nwr", 32'(nwr), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
